// File: rtl/branch_resolve_pkg.sv
// Shared types for the EX-stage branch resolution slice: branch type
// encodings, recovery FSM states and the default address width.
package branch_resolve_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_type_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/branch_resolve_pred_stage_reg.sv
// One pipeline register for the fetch prediction {valid, pc, pd, paddr}.
// Flush wins over stall so a squashed slot can never be held as valid.
module pred_stage_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            pd_d,
  input  logic [XLEN-1:0] paddr_d,
  output logic            valid_q,
  output logic [XLEN-1:0] pc_q,
  output logic            pd_q,
  output logic [XLEN-1:0] paddr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pd_q    <= 1'b0;
      paddr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pd_q    <= pd_d;
      paddr_q <= paddr_d;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves the EX-stage branch against the prediction carried from IF,
// redirects fetch on a mispredict, and emits predictor updates and stats.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validF,
  input  logic [XLEN-1:0] PCF,
  input  logic            pdF,
  input  logic [XLEN-1:0] paddrF,
  input  logic            stallD,
  input  logic            stallE,
  input  logic [XLEN-1:0] PCE,
  input  logic [2:0]      BranchTypeE,
  input  logic            BranchE,
  input  logic [XLEN-1:0] BrNPC,
  output logic            flushD,
  output logic            flushE,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_target,
  output logic [CNTW-1:0] branch_cnt,
  output logic [CNTW-1:0] mispred_cnt,
  output logic            dbg_state,
  output logic            dbg_pred_taken
);

  state_t          state;
  logic            id_valid, id_pd, ex_valid, ex_pd;
  logic [XLEN-1:0] id_pc, id_paddr, ex_pc, ex_paddr;
  logic            ex_flush;
  logic [XLEN-1:0] pc_seq, actual_npc, eff_paddr;
  logic            is_branch, actual_taken, pc_match, eff_pd;
  logic            resolve, mispredict;

  pred_stage_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stallD),
    .flush   (flushD),
    .valid_d (validF),
    .pc_d    (PCF),
    .pd_d    (pdF),
    .paddr_d (paddrF),
    .valid_q (id_valid),
    .pc_q    (id_pc),
    .pd_q    (id_pd),
    .paddr_q (id_paddr)
  );

  // The recovery cycle drains EX so the wrong-path ID slot never resolves.
  assign ex_flush = flushE | (state == S_RECOVER);

  pred_stage_reg #(.XLEN(XLEN)) u_id_ex (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stallE),
    .flush   (ex_flush),
    .valid_d (id_valid),
    .pc_d    (id_pc),
    .pd_d    (id_pd),
    .paddr_d (id_paddr),
    .valid_q (ex_valid),
    .pc_q    (ex_pc),
    .pd_q    (ex_pd),
    .paddr_q (ex_paddr)
  );

  always_comb begin
    pc_seq       = PCE + XLEN'(4);
    is_branch    = (BranchTypeE != BR_NONE);
    actual_taken = is_branch & BranchE;
    actual_npc   = actual_taken ? BrNPC : pc_seq;
    // A prediction tagged with another PC is stale; treat it as fall-through.
    pc_match     = (ex_pc == PCE);
    eff_pd       = pc_match ? ex_pd : 1'b0;
    eff_paddr    = pc_match ? ex_paddr : pc_seq;
    resolve      = (state == S_IDLE) & ~stallE & ex_valid;
    mispredict   = resolve & (actual_npc != eff_paddr);
    redirect     = mispredict;
    flushD       = mispredict;
    flushE       = mispredict;
    redirect_pc  = mispredict ? actual_npc : '0;
  end

  assign dbg_state      = (state == S_RECOVER);
  assign dbg_pred_taken = resolve & eff_pd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      upd_target  <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:    if (mispredict) state <= S_RECOVER;
        S_RECOVER: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
      upd_valid <= resolve & is_branch;
      if (resolve && is_branch) begin
        upd_pc     <= PCE;
        upd_taken  <= actual_taken;
        upd_target <= BrNPC;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNTW'(1);
      end
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNTW'(1);
    end
  end

endmodule
